// File: rtl/cpu_pkg.sv
// Shared types and constants for the reduced RISC-V pipeline.
// Holds the ID/EX control bundle, ALU op encodings and the bubble value.
package cpu_pkg;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src_imm;
        logic       op1_pc;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
    } ex_ctrl_t;

    // 3'b101 is reserved and never produced by decode
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/operand_forward.sv
// Three-way bypass mux for one source operand.
// MEM beats WB, and x0 is never forwarded.
module operand_forward #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [DATA_WIDTH-1:0] i_rs_data,
    input  logic [ADDR_WIDTH-1:0] i_mem_rd_addr,
    input  logic                  i_mem_reg_write,
    input  logic [DATA_WIDTH-1:0] i_mem_result,
    input  logic [ADDR_WIDTH-1:0] i_wb_rd_addr,
    input  logic                  i_wb_reg_write,
    input  logic [DATA_WIDTH-1:0] i_wb_result,
    output logic [DATA_WIDTH-1:0] o_fwd_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_reg_write && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_rs_addr);
    assign w_wb_hit  = i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_rs_addr);

    always_comb begin
        o_fwd_data = i_rs_data;
        if (w_mem_hit) begin
            o_fwd_data = i_mem_result;
        end else if (w_wb_hit) begin
            o_fwd_data = i_wb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use detection.
// Drives the ALU operands and control directly from the registered stage state.
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  ex_ctrl_t              id_ctrl,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_reg_write,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic                  wb_reg_write,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic                  ex_valid,
    output ex_ctrl_t              ex_ctrl,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [ADDR_WIDTH-1:0] ex_rd_addr,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic                  load_use_hazard
);

    logic                  r_valid;
    ex_ctrl_t              r_ctrl;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [ADDR_WIDTH-1:0] r_rs1_addr;
    logic [ADDR_WIDTH-1:0] r_rs2_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    logic [DATA_WIDTH-1:0] w_fwd_rs1;
    logic [DATA_WIDTH-1:0] w_fwd_rs2;

    operand_forward #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fwd_rs1 (
        .i_rs_addr      (r_rs1_addr),
        .i_rs_data      (r_rs1_data),
        .i_mem_rd_addr  (mem_rd_addr),
        .i_mem_reg_write(mem_reg_write),
        .i_mem_result   (mem_result),
        .i_wb_rd_addr   (wb_rd_addr),
        .i_wb_reg_write (wb_reg_write),
        .i_wb_result    (wb_result),
        .o_fwd_data     (w_fwd_rs1)
    );

    operand_forward #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fwd_rs2 (
        .i_rs_addr      (r_rs2_addr),
        .i_rs_data      (r_rs2_data),
        .i_mem_rd_addr  (mem_rd_addr),
        .i_mem_reg_write(mem_reg_write),
        .i_mem_result   (mem_result),
        .i_wb_rd_addr   (wb_rd_addr),
        .i_wb_reg_write (wb_reg_write),
        .i_wb_result    (wb_result),
        .o_fwd_data     (w_fwd_rs2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_ctrl     <= EX_CTRL_NOP;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_ctrl     <= EX_CTRL_NOP;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
        end else if (stall) begin
            // Keep bypassed values so a producer retiring from WB mid-stall is not lost
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end else begin
            r_valid    <= id_valid;
            r_ctrl     <= id_ctrl;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1_addr <= id_rs1_addr;
            r_rs2_addr <= id_rs2_addr;
            r_rd_addr  <= id_rd_addr;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_ctrl       = r_ctrl;
    assign ex_pc         = r_pc;
    assign ex_rd_addr    = r_rd_addr;
    assign ALUop1        = r_ctrl.op1_pc ? r_pc : w_fwd_rs1;
    assign ALUop2        = r_ctrl.alu_src_imm ? r_imm : w_fwd_rs2;
    assign ALUctrl       = r_ctrl.alu_ctrl;
    assign ex_store_data = w_fwd_rs2;

    // Conservative: rs2 may match even when the ID instruction does not read it
    assign load_use_hazard = r_valid && r_ctrl.mem_read && (r_rd_addr != '0) && id_valid &&
                             ((r_rd_addr == id_rs1_addr) || (r_rd_addr == id_rs2_addr));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage: reset, forwarding, load-use, stall, imm/pc select.
module tb_ex_operand_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    ex_ctrl_t    id_ctrl;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid;
    ex_ctrl_t    ex_ctrl;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ALUop1, ALUop2, ex_store_data;
    logic [2:0]  ALUctrl;
    logic        load_use_hazard;

    int n_vec;
    int n_err;

    ex_operand_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_ctrl        (id_ctrl),
        .id_pc          (id_pc),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_rd_addr     (id_rd_addr),
        .mem_rd_addr    (mem_rd_addr),
        .mem_reg_write  (mem_reg_write),
        .mem_result     (mem_result),
        .wb_rd_addr     (wb_rd_addr),
        .wb_reg_write   (wb_reg_write),
        .wb_result      (wb_result),
        .ex_valid       (ex_valid),
        .ex_ctrl        (ex_ctrl),
        .ex_pc          (ex_pc),
        .ex_rd_addr     (ex_rd_addr),
        .ALUop1         (ALUop1),
        .ALUop2         (ALUop2),
        .ALUctrl        (ALUctrl),
        .ex_store_data  (ex_store_data),
        .load_use_hazard(load_use_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction on the ID side and clock it into EX
    task automatic load_id(input ex_ctrl_t c, input logic [31:0] pc, input logic [4:0] a1,
                           input logic [31:0] d1, input logic [4:0] a2, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [4:0] rd);
        id_valid    = 1'b1;
        id_ctrl     = c;
        id_pc       = pc;
        id_rs1_addr = a1;
        id_rs1_data = d1;
        id_rs2_addr = a2;
        id_rs2_data = d2;
        id_imm      = imm;
        id_rd_addr  = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        mem_rd_addr   = '0;
        mem_reg_write = 1'b0;
        mem_result    = '0;
        wb_rd_addr    = '0;
        wb_reg_write  = 1'b0;
        wb_result     = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; flush = 0; id_valid = 0; id_ctrl = '0;
        id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        clear_bypass();
        #3;
        n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        n_vec++; if (ex_ctrl !== 10'd0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", ex_ctrl); end
        n_vec++; if (ALUctrl !== 3'b000) begin n_err++; $display("FAIL reset_aluctrl got %b want 000", ALUctrl); end
        n_vec++; if (ALUop1 !== 32'd0) begin n_err++; $display("FAIL reset_op1 got %h want 0", ALUop1); end
        n_vec++; if (ALUop2 !== 32'd0) begin n_err++; $display("FAIL reset_op2 got %h want 0", ALUop2); end
        n_vec++; if (ex_store_data !== 32'd0) begin n_err++; $display("FAIL reset_store got %h want 0", ex_store_data); end
        n_vec++; if (load_use_hazard !== 1'b0) begin n_err++; $display("FAIL reset_luh got %b want 0", load_use_hazard); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        ex_ctrl_t c;
        c = '0; c.alu_ctrl = ALU_ADD; c.reg_write = 1'b1;
        load_id(c, 32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3);
        n_vec++; if (ALUop1 !== 32'd5) begin n_err++; $display("FAIL add_op1 got %h want 5", ALUop1); end
        n_vec++; if (ALUop2 !== 32'd7) begin n_err++; $display("FAIL add_op2 got %h want 7", ALUop2); end
        n_vec++; if (ALUctrl !== 3'b000) begin n_err++; $display("FAIL add_aluctrl got %b want 000", ALUctrl); end
        n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", ex_valid); end
        n_vec++; if (ex_rd_addr !== 5'd3) begin n_err++; $display("FAIL add_rd got %0d want 3", ex_rd_addr); end
        n_vec++; if (ex_pc !== 32'h40) begin n_err++; $display("FAIL add_pc got %h want 40", ex_pc); end
        n_vec++; if (ex_store_data !== 32'd7) begin n_err++; $display("FAIL add_store got %h want 7", ex_store_data); end
    endtask

    task automatic test_bypass_priority();
        ex_ctrl_t c;
        c = '0; c.alu_ctrl = ALU_OR; c.reg_write = 1'b1;
        load_id(c, 32'h44, 5'd4, 32'h11, 5'd2, 32'h22, 32'd0, 5'd8);
        mem_rd_addr = 5'd4; mem_reg_write = 1'b1; mem_result = 32'hAA;
        wb_rd_addr  = 5'd4; wb_reg_write  = 1'b1; wb_result  = 32'hBB;
        #1;
        n_vec++; if (ALUop1 !== 32'hAA) begin n_err++; $display("FAIL fwd_mem_prio got %h want aa", ALUop1); end
        n_vec++; if (ALUop2 !== 32'h22) begin n_err++; $display("FAIL fwd_rs2_untouched got %h want 22", ALUop2); end
        n_vec++; if (ALUctrl !== ALU_OR) begin n_err++; $display("FAIL fwd_aluctrl got %b want 011", ALUctrl); end
        mem_reg_write = 1'b0;
        #1;
        n_vec++; if (ALUop1 !== 32'hBB) begin n_err++; $display("FAIL fwd_wb got %h want bb", ALUop1); end
        wb_rd_addr = 5'd2;
        #1;
        n_vec++; if (ALUop1 !== 32'h11) begin n_err++; $display("FAIL fwd_none got %h want 11", ALUop1); end
        n_vec++; if (ex_store_data !== 32'hBB) begin n_err++; $display("FAIL fwd_store_wb got %h want bb", ex_store_data); end
        clear_bypass();
    endtask

    task automatic test_x0_not_forwarded();
        ex_ctrl_t c;
        c = '0; c.alu_ctrl = ALU_ADD; c.reg_write = 1'b1;
        load_id(c, 32'h48, 5'd0, 32'd0, 5'd0, 32'h55, 32'd0, 5'd9);
        mem_rd_addr = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hFF;
        wb_rd_addr  = 5'd0; wb_reg_write  = 1'b1; wb_result  = 32'hEE;
        #1;
        n_vec++; if (ALUop1 !== 32'd0) begin n_err++; $display("FAIL x0_op1 got %h want 0", ALUop1); end
        n_vec++; if (ALUop2 !== 32'h55) begin n_err++; $display("FAIL x0_op2 got %h want 55", ALUop2); end
        clear_bypass();
    endtask

    task automatic test_load_use();
        ex_ctrl_t c;
        c = '0; c.alu_ctrl = ALU_ADD; c.alu_src_imm = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1;
        load_id(c, 32'h4C, 5'd1, 32'd5, 5'd0, 32'd0, 32'd4, 5'd5);
        id_rs1_addr = 5'd9; id_rs2_addr = 5'd5;
        #1;
        n_vec++; if (load_use_hazard !== 1'b1) begin n_err++; $display("FAIL luh_rs2 got %b want 1", load_use_hazard); end
        n_vec++; if (ALUop2 !== 32'd4) begin n_err++; $display("FAIL luh_imm got %h want 4", ALUop2); end
        id_valid = 1'b0;
        #1;
        n_vec++; if (load_use_hazard !== 1'b0) begin n_err++; $display("FAIL luh_idinvalid got %b want 0", load_use_hazard); end
        id_valid = 1'b1; id_rs2_addr = 5'd7;
        #1;
        n_vec++; if (load_use_hazard !== 1'b0) begin n_err++; $display("FAIL luh_nomatch got %b want 0", load_use_hazard); end
        id_rs2_addr = 5'd5; flush = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", ex_valid); end
        n_vec++; if (ex_ctrl !== 10'd0) begin n_err++; $display("FAIL flush_ctrl got %h want 0", ex_ctrl); end
        n_vec++; if (load_use_hazard !== 1'b0) begin n_err++; $display("FAIL flush_luh got %b want 0", load_use_hazard); end
        n_vec++; if (ex_rd_addr !== 5'd0) begin n_err++; $display("FAIL flush_rd got %0d want 0", ex_rd_addr); end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_stall_capture();
        ex_ctrl_t c;
        c = '0; c.alu_ctrl = ALU_XOR; c.reg_write = 1'b1;
        load_id(c, 32'h50, 5'd6, 32'h0, 5'd3, 32'h33, 32'd0, 5'd10);
        stall = 1'b1;
        id_ctrl = '0; id_pc = 32'h999; id_rs1_data = 32'h9999; id_rd_addr = 5'd31;
        wb_rd_addr = 5'd6; wb_reg_write = 1'b1; wb_result = 32'h1234;
        #1;
        n_vec++; if (ALUop1 !== 32'h1234) begin n_err++; $display("FAIL stall_fwd_live got %h want 1234", ALUop1); end
        @(posedge clk); #1;
        clear_bypass();
        #1;
        n_vec++; if (ALUop1 !== 32'h1234) begin n_err++; $display("FAIL stall_cap1 got %h want 1234", ALUop1); end
        @(posedge clk); #1;
        n_vec++; if (ALUop1 !== 32'h1234) begin n_err++; $display("FAIL stall_cap2 got %h want 1234", ALUop1); end
        n_vec++; if (ex_pc !== 32'h50) begin n_err++; $display("FAIL stall_pc_hold got %h want 50", ex_pc); end
        n_vec++; if (ALUctrl !== ALU_XOR) begin n_err++; $display("FAIL stall_ctrl_hold got %b want 100", ALUctrl); end
        n_vec++; if (ex_rd_addr !== 5'd10) begin n_err++; $display("FAIL stall_rd_hold got %0d want 10", ex_rd_addr); end
        stall = 1'b0;
    endtask

    task automatic test_imm_pc_reset();
        ex_ctrl_t c;
        c = '0; c.alu_ctrl = ALU_SUB; c.op1_pc = 1'b1; c.alu_src_imm = 1'b1; c.jump = 1'b1;
        load_id(c, 32'h100, 5'd1, 32'h77, 5'd2, 32'h88, 32'h10, 5'd1);
        n_vec++; if (ALUop1 !== 32'h100) begin n_err++; $display("FAIL pc_op1 got %h want 100", ALUop1); end
        n_vec++; if (ALUop2 !== 32'h10) begin n_err++; $display("FAIL imm_op2 got %h want 10", ALUop2); end
        n_vec++; if (ALUctrl !== ALU_SUB) begin n_err++; $display("FAIL imm_aluctrl got %b want 001", ALUctrl); end
        n_vec++; if (ex_store_data !== 32'h88) begin n_err++; $display("FAIL imm_store got %h want 88", ex_store_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", ex_valid); end
        n_vec++; if (ex_ctrl !== 10'd0) begin n_err++; $display("FAIL arst_ctrl got %h want 0", ex_ctrl); end
        n_vec++; if (ALUop1 !== 32'd0) begin n_err++; $display("FAIL arst_op1 got %h want 0", ALUop1); end
        n_vec++; if (ALUop2 !== 32'd0) begin n_err++; $display("FAIL arst_op2 got %h want 0", ALUop2); end
        n_vec++; if (ex_pc !== 32'd0) begin n_err++; $display("FAIL arst_pc got %h want 0", ex_pc); end
        n_vec++; if (ex_store_data !== 32'd0) begin n_err++; $display("FAIL arst_store got %h want 0", ex_store_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_add();
        test_bypass_priority();
        test_x0_not_forwarded();
        test_load_use();
        test_stall_capture();
        test_imm_pc_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register with operand forwarding for the reduced RISC-V pipeline. It captures decoded instruction state at the ID→EX boundary and resolves RAW hazards by bypassing MEM- and WB-stage results. It drives the ALU operand and control inputs directly. It also flags load-use hazards so the hazard unit can stall the front end and bubble this stage.

## Interface
- DATA_WIDTH, 32, datapath width
- ADDR_WIDTH, 5, register index width

- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold stage contents
- flush  in  1  load a bubble; priority over stall
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  ex_ctrl_t  decoded controls: alu_ctrl[2:0], alu_src_imm, op1_pc, reg_write, mem_read, mem_write, branch, jump
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  DATA_WIDTH  decoded operands
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  ADDR_WIDTH  register indices
- mem_rd_addr  in  ADDR_WIDTH; mem_reg_write  in  1; mem_result  in  DATA_WIDTH  MEM-stage bypass source
- wb_rd_addr  in  ADDR_WIDTH; wb_reg_write  in  1; wb_result  in  DATA_WIDTH  WB-stage bypass source
- ex_valid  out  1; ex_ctrl  out  ex_ctrl_t; ex_pc  out  DATA_WIDTH; ex_rd_addr  out  ADDR_WIDTH  registered state
- ALUop1, ALUop2  out  DATA_WIDTH  ALU operands
- ALUctrl  out  3  ALU operation
- ex_store_data  out  DATA_WIDTH  forwarded rs2 for stores
- load_use_hazard  out  1  stall request to the hazard unit

## Operation
- Registered state: valid, ctrl, pc, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr.
- Each rising clk edge:
  - flush=1: valid←0, ctrl←all-zero (bubble), all other registers←0.
  - else stall=1: all registers hold, except rs1_data/rs2_data, which load the currently forwarded values.
  - else: load all registers from the id_* inputs.
- The forwarded-value capture during stall is what stops a producer retiring out of WB during the stall from being lost.
- Forwarding (combinational, per operand, for rsN in {rs1, rs2}):
  - If mem_reg_write && mem_rd_addr≠0 && mem_rd_addr==rsN_addr, select mem_result.
  - Else if wb_reg_write && wb_rd_addr≠0 && wb_rd_addr==rsN_addr, select wb_result.
  - Else select the registered rsN_data.
  - MEM has priority over WB. x0 is never forwarded.
- Operand and control selection:
  - ALUop1 = ctrl.op1_pc ? pc : fwd_rs1.
  - ALUop2 = ctrl.alu_src_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2.
  - ALUctrl = ctrl.alu_ctrl. Encoding 101 is reserved and is never produced by decode.
- load_use_hazard = valid && ctrl.mem_read && rd_addr≠0 && id_valid && (rd_addr==id_rs1_addr || rd_addr==id_rs2_addr).
  - It is conservative: an unused rs2 may match.
  - The hazard unit responds with stall on IF/ID and flush on this stage in the same cycle.
- Register-file write-through for the ID read is owned by the register file, not by this block.

## Timing
- Async reset: every register is 0 immediately. Consequently ex_valid=0, ex_ctrl=0, ALUctrl=000 (add), ALUop1=ALUop2=0 (absent active bypass sources), ex_store_data=0, load_use_hazard=0.
- Reset deassertion is synchronised externally. The first capture happens on the first clk edge with rst_n high.
- Latency: id_* → ex_* is 1 cycle. Forwarding, operand muxing and load_use_hazard are zero-cycle combinational.
- flush and stall in the same cycle: flush wins.
- A bubble (ex_valid=0) never asserts load_use_hazard. Its outputs still drive the ALU (add of zeros), which is harmless.
- MEM and WB both matching the same rsN: MEM value is used.
- Reset mid-stall or mid-flush: reset overrides both.

## Structure
- cpu_pkg holds:
  - ex_ctrl_t packed struct.
  - ALU op constants: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_SLL=110, ALU_SRL=111.
  - Bubble constant EX_CTRL_NOP.
- Sub-module operand_forward is the combinational 3-way bypass mux with x0 and priority rules. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- Reset, then load add x3,x1,x2 with rs1=5, rs2=7, no bypass active → next cycle ALUop1=5, ALUop2=7, ALUctrl=000, ex_valid=1.
- Bypass priority: EX rs1=x4; mem_rd=4 with mem_result=0xAA; wb_rd=4 with wb_result=0xBB → ALUop1=0xAA. Drop mem_reg_write → ALUop1=0xBB.
- x0 never forwarded: rs1=x0, mem_rd=0, mem_reg_write=1, mem_result=0xFF → ALUop1 = registered value (0).
- Load-use: EX holds lw x5 (mem_read=1); ID has id_rs2_addr=5 → load_use_hazard=1. Next cycle with flush=1 → ex_valid=0, ex_ctrl=0, load_use_hazard=0.
- Stall capture: stall=1 for 2 cycles while wb_rd=6 writes 0x1234 in the first cycle only; EX rs1=x6 → ALUop1 stays 0x1234 in the second cycle.
- Immediate/PC select plus async reset: op1_pc=1, alu_src_imm=1, pc=0x100, imm=0x10 → ALUop1=0x100, ALUop2=0x10. Asserting rst_n=0 mid-cycle zeroes all outputs immediately.
